fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory; the instruction word returns in the same cycle.
- Registers PC, PC+4 and the instruction word into the IF/ID pipeline register consumed by decode.
- Honours stall from the hazard unit and redirect/flush from branch/jump resolution.

Parameters:
- XLEN, 32, address and instruction width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction-memory size in bytes; fetches at or beyond it produce bubbles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold: freeze PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved this cycle.
- redirect_pc  in  XLEN  target address for the redirect.
- imem_addr  out  XLEN  byte address to instruction memory, equal to pc.
- imem_inst  in  XLEN  instruction word returned combinationally.
- pc  out  XLEN  current PC register.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_pc_plus4  out  XLEN  that PC + 4.
- if_id_inst  out  XLEN  instruction word; NOP (all zero) when invalid.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC.
  - if_id_valid = 0.
  - if_id_pc, if_id_pc_plus4 and if_id_inst = 0.
- imem_addr = pc, combinational, with zero added latency. Fetch-to-IF/ID latency is 1 cycle.
- Per-edge priority is rst > redirect_valid > stall > normal.
  - Normal: pc <= pc+4. IF/ID loads {pc, pc+4, imem_inst} with valid = in_range.
  - Stall (no redirect): pc and all IF/ID fields hold. imem_addr stays constant.
  - Redirect: pc <= {redirect_pc[XLEN-1:2], 2'b00}. IF/ID is flushed to valid = 0, inst = 0, pc fields = 0. Redirect overrides a simultaneous stall.
- in_range = (pc < IMEM_BYTES). When it is false, the IF/ID load is a bubble (valid 0, inst 0), but pc still advances.
- Arithmetic:
  - pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - pc[1:0] is always 00.
- Reset asserted mid-stall or mid-redirect: reset wins, and the next cycle fetches RESET_PC.
- A stall released in the cycle after a redirect resumes normally from the new pc.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched (32) and perf_bubbles (32), both reset to 0.
  - perf_fetched increments on every IF/ID load with valid = 1.
  - perf_bubbles increments on every cycle in which IF/ID is valid = 0 after the edge and rst is low, covering flushes, out-of-range fetches and post-reset idle.
  - Stall cycles count in neither counter.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - XLEN, NOP_INST = 32'h0000_0000, DEFAULT_RESET_PC.
  - typedef if_id_t as a packed struct {valid, pc, pc_plus4, inst}.
- One sub-module, if_id_reg, implements the IF/ID pipeline register:
  - inputs load, flush, d (if_id_t); output q.
  - priority rst > flush > !load hold.
- fetch_stage keeps the PC logic and redirect/stall arbitration.

Test Plan:
- Reset then 3 free-running cycles with imem returning 0xA, 0xB, 0xC -> pc 0→4→8→12; IF/ID sequence (0, 0xA, v=1), (4, 0xB), (8, 0xC).
- Stall held 2 cycles at pc=8 -> pc stays 8, imem_addr stays 8, IF/ID stays (4, 0xB, v=1); on release it loads (8, inst) and pc becomes 12.
- redirect_valid with redirect_pc=0x43 while stall=1 at pc=16 -> pc=0x40, if_id_valid=0, if_id_inst=0; next cycle IF/ID = (0x40, imem_inst, v=1).
- IMEM_BYTES=16 with pc reaching 16 -> pc advances to 20, if_id_valid=0, inst=0; a redirect to 0 restores valid fetches.
- pc forced via redirect to 0xFFFF_FFFC -> next pc = 0, if_id_pc_plus4 = 0 (wrap).
- rst asserted on the same edge as a redirect to 0x80 -> pc = RESET_PC and IF/ID cleared. With IF_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline: IF/ID register layout,
// NOP encoding and small arithmetic helpers used by the fetch stage.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{valid: 1'b0, pc: '0, pc_plus4: '0, inst: NOP_INST};

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush clear it to a bubble, a deasserted
// load holds the current contents.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= IF_ID_EMPTY;
    end else if (flush) begin
      q <= IF_ID_EMPTY;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, arbitrates redirect over stall and
// feeds the IF/ID register. Define IF_PERF_CNT_EN to add fetch/bubble counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              XLEN       = mips_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = mips_pkg::DEFAULT_RESET_PC,
  parameter int              IMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  output logic [XLEN-1:0] pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            in_range;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign in_range  = (pc_q < XLEN'(IMEM_BYTES));
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // Out-of-range fetches still record their PC but carry a NOP and valid=0.
  always_comb begin
    if_id_d          = IF_ID_EMPTY;
    if_id_d.valid    = in_range;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.inst     = in_range ? imem_inst : NOP_INST;
  end

  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (!stall) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (!stall),
    .flush (redirect_valid),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_valid    = if_id_q.valid;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_inst     = if_id_q.inst;

`ifdef IF_PERF_CNT_EN
  // A flush counts as a bubble even when it coincides with a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (redirect_valid) begin
      perf_bubbles <= sat_inc(perf_bubbles);
    end else if (!stall) begin
      if (in_range) begin
        perf_fetched <= sat_inc(perf_fetched);
      end else begin
        perf_bubbles <= sat_inc(perf_bubbles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_fetch_stage;

  localparam int          IMEM_BYTES = 1024;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: word at byte address a is 0xA + a/4.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0000_000A + (addr >> 2);
  endfunction

  assign imem_inst = mem_word(imem_addr);

  fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_inst     (if_id_inst)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic v,
                                input logic [31:0] target);
    rst            = r;
    stall          = s;
    redirect_valid = v;
    redirect_pc    = target;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what the pipeline must contain after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_cur;
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_pc4;
  logic [31:0] m_if_inst;
  longint      m_fetched;
  longint      m_bubbles;
  bit          model_ready = 1'b0;

  function automatic logic [31:0] saturate(input longint count);
    longint limit;
    limit = 64'h0000_0000_FFFF_FFFF;
    return (count > limit) ? 32'hFFFF_FFFF : count[31:0];
  endfunction

  always @(posedge clk) begin
    m_cur = m_pc;
    if (rst) begin
      m_pc        = RESET_PC;
      m_valid     = 1'b0;
      m_if_pc     = 32'd0;
      m_if_pc4    = 32'd0;
      m_if_inst   = 32'd0;
      m_fetched   = 0;
      m_bubbles   = 0;
      model_ready = 1'b1;
    end else if (redirect_valid) begin
      m_pc      = redirect_pc - (redirect_pc % 4);
      m_valid   = 1'b0;
      m_if_pc   = 32'd0;
      m_if_pc4  = 32'd0;
      m_if_inst = 32'd0;
      m_bubbles = m_bubbles + 1;
    end else if (!stall) begin
      m_valid   = (m_cur < IMEM_BYTES);
      m_if_pc   = m_cur;
      m_if_pc4  = m_cur + 32'd4;
      m_if_inst = m_valid ? mem_word(m_cur) : 32'd0;
      if (m_valid) m_fetched = m_fetched + 1;
      else         m_bubbles = m_bubbles + 1;
      m_pc = m_cur + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("model_pc",        pc,                    m_pc);
      check_output("model_imem_addr", imem_addr,             m_pc);
      check_output("model_valid",     {31'd0, if_id_valid},  {31'd0, m_valid});
      check_output("model_if_pc",     if_id_pc,              m_if_pc);
      check_output("model_if_pc4",    if_id_pc_plus4,        m_if_pc4);
      check_output("model_if_inst",   if_id_inst,            m_if_inst);
`ifdef IF_PERF_CNT_EN
      check_output("model_fetched",   perf_fetched,          saturate(m_fetched));
      check_output("model_bubbles",   perf_bubbles,          saturate(m_bubbles));
`endif
    end
  end

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_pc",    pc,                   32'h0);
    check_output("reset_valid", {31'd0, if_id_valid}, 32'h0);
    check_output("reset_inst",  if_id_inst,           32'h0);
    check_output("reset_if_pc", if_id_pc,             32'h0);

    // Free-running fetch from 0
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("run0_pc",   pc,                   32'h4);
    check_output("run0_inst", if_id_inst,           32'hA);
    check_output("run0_valid",{31'd0, if_id_valid}, 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("run1_pc",    pc,         32'h8);
    check_output("run1_if_pc", if_id_pc,   32'h4);
    check_output("run1_inst",  if_id_inst, 32'hB);

    // Two stalled cycles at pc=8
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("stall_pc",        pc,             32'h8);
      check_output("stall_imem_addr", imem_addr,      32'h8);
      check_output("stall_if_pc",     if_id_pc,       32'h4);
      check_output("stall_inst",      if_id_inst,     32'hB);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("release_pc",     pc,             32'hC);
    check_output("release_if_pc",  if_id_pc,       32'h8);
    check_output("release_if_pc4", if_id_pc_plus4, 32'hC);
    check_output("release_inst",   if_id_inst,     32'hC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("run3_pc", pc, 32'h10);

    // Redirect to an unaligned target overrides a simultaneous stall
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h43);
    check_output("redir_pc",    pc,                   32'h40);
    check_output("redir_valid", {31'd0, if_id_valid}, 32'h0);
    check_output("redir_inst",  if_id_inst,           32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("post_redir_if_pc", if_id_pc,             32'h40);
    check_output("post_redir_inst",  if_id_inst,           32'h1A);
    check_output("post_redir_valid", {31'd0, if_id_valid}, 32'h1);

    // Walk across the end of instruction memory
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h3F8);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("last_word_inst", if_id_inst, 32'h109);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("oor_pc",    pc,                   32'h404);
    check_output("oor_if_pc", if_id_pc,             32'h400);
    check_output("oor_valid", {31'd0, if_id_valid}, 32'h0);
    check_output("oor_inst",  if_id_inst,           32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("back_in_range_valid", {31'd0, if_id_valid}, 32'h1);
    check_output("back_in_range_inst",  if_id_inst,           32'hA);

    // PC wraps past the top of the address space
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check_output("top_pc", pc, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("wrap_pc",     pc,             32'h0);
    check_output("wrap_if_pc4", if_id_pc_plus4, 32'h0);
    check_output("wrap_if_pc",  if_id_pc,       32'hFFFF_FFFC);

    // Pseudo-random mix of stalls and redirects, checked by the model
    for (int i = 0; i < 60; i++) begin
      int unsigned pick;
      pick = $urandom_range(0, 9);
      apply_stimulus(1'b0, pick < 3, pick >= 8, 32'($urandom_range(0, 32'h44F)));
    end

    // Reset wins over a simultaneous redirect and stall
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80);
    check_output("rst_redir_pc",    pc,                   RESET_PC);
    check_output("rst_redir_valid", {31'd0, if_id_valid}, 32'h0);
    check_output("rst_redir_if_pc", if_id_pc,             32'h0);
    check_output("rst_redir_inst",  if_id_inst,           32'h0);
`ifdef IF_PERF_CNT_EN
    check_output("rst_fetched", perf_fetched, 32'h0);
    check_output("rst_bubbles", perf_bubbles, 32'h0);
`endif
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("after_rst_pc",   pc,         32'h4);
    check_output("after_rst_inst", if_id_inst, 32'hA);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
